// File: rtl/x_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : x_seq_pkg
// Brief    : Shared state encoding and width helpers for the x_seq sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package x_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle     = 2'd0;
    localparam state_t c_st_send     = 2'd1;
    localparam state_t c_st_wait_sen = 2'd2;
    localparam state_t c_st_clear    = 2'd3;

    // Width of the binary channel id; a single channel still needs one bit.
    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the bit index, able to hold 0..WIDTH.
    function automatic int idxw(input int w);
        return $clog2(w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/x_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : x_seq_if
// Brief    : Channel request / serial handshake bundle of the x_seq sequencer.
//            master = channel sources and link side, slave = the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface x_seq_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2
);
    import x_seq_pkg::*;

    localparam int c_chw  = chw(NCH);
    localparam int c_idxw = idxw(WIDTH);

    logic [NCH-1:0]       req;
    logic [NCH*WIDTH-1:0] data_in;
    logic                 ack;
    logic                 senack;
    logic                 busy;
    logic [NCH-1:0]       grant;
    logic [c_chw-1:0]     ch_id;
    logic [c_idxw-1:0]    bit_idx;
    logic                 tx_bit;
    logic                 dt;
    logic                 cclear;
    logic                 done;
    logic                 err;

    modport master (
        output req, data_in, ack, senack,
        input  busy, grant, ch_id, bit_idx, tx_bit, dt, cclear, done, err
    );

    modport slave (
        input  req, data_in, ack, senack,
        output busy, grant, ch_id, bit_idx, tx_bit, dt, cclear, done, err
    );

endinterface
`default_nettype wire

// File: rtl/x_seq_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : x_seq_rr_arb
// Brief    : Combinational round-robin arbiter. Picks the first set request at
//            or after ptr, wrapping, and returns it one-hot and binary.
// Revision : 1.0 - initial release
// ============================================================================
module x_seq_rr_arb
    import x_seq_pkg::*;
#(
    parameter  int NCH   = 2,
    localparam int c_chw = chw(NCH)
) (
    input  wire logic [NCH-1:0]   req,
    input  wire logic [c_chw-1:0] ptr,
    output logic      [NCH-1:0]   grant,
    output logic      [c_chw-1:0] id
);

    logic w_found;

    // Scan distances from ptr in increasing order; first requesting channel wins.
    always_comb begin
        grant   = '0;
        id      = '0;
        w_found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!w_found && req[c] && (((int'(ptr) + i) % NCH) == c)) begin
                    w_found  = 1'b1;
                    grant[c] = 1'b1;
                    id       = c_chw'(c);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/x_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : x_seq_ctrl
// Brief    : Handshake bit-sequencer. Arbitrates NCH channels round-robin,
//            latches the winner's word and presents it one bit per receiver
//            ack rising edge, then waits for senack and pulses clear/done.
//            Optional wait-state timeout enabled by macro X_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module x_seq_ctrl
    import x_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NCH     = 2,
    parameter int TIMEOUT = 255
) (
    input wire logic clk,
    input wire logic reset,
    x_seq_if.slave   bus
);

    localparam int c_chw  = chw(NCH);
    localparam int c_idxw = idxw(WIDTH);

    // Reject parameter sets the datapath cannot represent.
    if (WIDTH < 1 || NCH < 1 || TIMEOUT < 1) begin : g_param_check
        $error("x_seq_ctrl: WIDTH, NCH and TIMEOUT must all be >= 1");
    end

    state_t             r_state;
    state_t             w_next_state;
    logic               r_ack_q;
    logic               w_ack_rise;
    logic [WIDTH-1:0]   r_word;
    logic [NCH-1:0]     r_grant;
    logic [c_chw-1:0]   r_ch_id;
    logic [c_idxw-1:0]  r_bit_idx;
    logic [c_chw-1:0]   r_ptr;
    logic               r_abort;
    logic               w_abort_set;
    logic               w_timeout_hit;
    logic               w_last_bit;
    logic               w_tx_bit;
    logic [NCH-1:0]     w_arb_grant;
    logic [c_chw-1:0]   w_arb_id;
    logic [c_chw-1:0]   w_next_ptr;
    logic [WIDTH-1:0]   w_sel_word;

    x_seq_rr_arb #(
        .NCH   (NCH)
    ) u_arb (
        .req   (bus.req),
        .ptr   (r_ptr),
        .grant (w_arb_grant),
        .id    (w_arb_id)
    );

    assign w_ack_rise = bus.ack & ~r_ack_q;
    assign w_last_bit = (r_bit_idx == c_idxw'(WIDTH - 1));
    assign w_next_ptr = c_chw'((int'(w_arb_id) + 1) % NCH);

    // Pick the winning channel's word out of the flat data bus.
    always_comb begin
        w_sel_word = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_arb_grant[c]) begin
                w_sel_word = bus.data_in[c*WIDTH +: WIDTH];
            end
        end
    end

    // Present the latched word bit addressed by the current index.
    always_comb begin
        w_tx_bit = 1'b0;
        for (int b = 0; b < WIDTH; b++) begin
            if (r_bit_idx == c_idxw'(b)) begin
                w_tx_bit = r_word[b];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; an ack edge in SEND and senack in WAIT_SEN take
    // precedence over a coincident timeout.
    always_comb begin
        w_next_state = r_state;
        w_abort_set  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (|bus.req) begin
                    w_next_state = c_st_send;
                end
            end
            c_st_send: begin
                if (w_ack_rise) begin
                    if (w_last_bit) begin
                        w_next_state = c_st_wait_sen;
                    end
                end else if (w_timeout_hit) begin
                    w_next_state = c_st_clear;
                    w_abort_set  = 1'b1;
                end
            end
            c_st_wait_sen: begin
                if (bus.senack) begin
                    w_next_state = c_st_clear;
                end else if (w_timeout_hit) begin
                    w_next_state = c_st_clear;
                    w_abort_set  = 1'b1;
                end
            end
            c_st_clear: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Datapath: ack history, grant/word latch, bit index and abort flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack_q   <= 1'b0;
            r_word    <= '0;
            r_grant   <= '0;
            r_ch_id   <= '0;
            r_bit_idx <= '0;
            r_ptr     <= '0;
            r_abort   <= 1'b0;
        end else begin
            r_ack_q <= bus.ack;
            case (r_state)
                c_st_idle: begin
                    if (|bus.req) begin
                        r_word    <= w_sel_word;
                        r_grant   <= w_arb_grant;
                        r_ch_id   <= w_arb_id;
                        r_bit_idx <= '0;
                        r_ptr     <= w_next_ptr;
                        r_abort   <= 1'b0;
                    end
                end
                c_st_send: begin
                    if (w_ack_rise && !w_last_bit) begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                    if (w_abort_set) begin
                        r_abort <= 1'b1;
                    end
                end
                c_st_wait_sen: begin
                    if (w_abort_set) begin
                        r_abort <= 1'b1;
                    end
                end
                c_st_clear: begin
                    r_grant   <= '0;
                    r_ch_id   <= '0;
                    r_bit_idx <= '0;
                    r_abort   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef X_SEQ_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Wait-state watchdog: restarts on every state entry and on each ack edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((w_next_state != r_state) || w_ack_rise) begin
            r_cnt <= '0;
        end else if ((r_state == c_st_send) || (r_state == c_st_wait_sen)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout_hit = ((r_state == c_st_send) || (r_state == c_st_wait_sen)) &&
                           (r_cnt == c_cnt_w'(TIMEOUT));
    assign bus.err       = (r_state == c_st_clear) & r_abort;
`else
    assign w_timeout_hit = 1'b0;
    assign bus.err       = 1'b0;
`endif

    assign bus.busy    = (r_state != c_st_idle);
    assign bus.dt      = (r_state == c_st_send);
    assign bus.cclear  = (r_state == c_st_clear);
    assign bus.done    = (r_state == c_st_clear) & ~r_abort;
    assign bus.grant   = r_grant;
    assign bus.ch_id   = r_ch_id;
    assign bus.bit_idx = r_bit_idx;
    assign bus.tx_bit  = w_tx_bit;

endmodule
`default_nettype wire

// File: tb/tb_x_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_x_seq_ctrl
// Brief    : Self-checking bench for x_seq_ctrl (WIDTH=8, NCH=2, TIMEOUT=10).
//            Abort scenarios are exercised when X_SEQ_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_x_seq_ctrl;
    import x_seq_pkg::*;

    localparam int WIDTH   = 8;
    localparam int NCH     = 2;
    localparam int TIMEOUT = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    x_seq_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

    x_seq_ctrl #(
        .WIDTH   (WIDTH),
        .NCH     (NCH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int               ch;
        logic [WIDTH-1:0] word;
    } exp_t;

    exp_t sb_q[$];
    int   m_ptr    = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [NCH-1:0] r);
        for (int i = 0; i < NCH; i++) begin
            int c;
            c = (m_ptr + i) % NCH;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive_req(input logic [NCH-1:0] r, input logic [WIDTH-1:0] w0,
                             input logic [WIDTH-1:0] w1);
        exp_t e;
        int   win;
        bus.req     = r;
        bus.data_in = {w1, w0};
        win = model_pick(r);
        if (win >= 0) begin
            e.ch   = win;
            e.word = (win == 0) ? w0 : w1;
            sb_q.push_back(e);
            m_ptr = (win + 1) % NCH;
        end
    endtask

    task automatic check_grant(output exp_t e);
        e = sb_q.pop_front();
        check_val("busy_on_grant", 32'(bus.busy), 32'd1);
        check_val("grant", 32'(bus.grant), 32'(1 << e.ch));
        check_val("ch_id", 32'(bus.ch_id), 32'(e.ch));
        check_val("dt_on_grant", 32'(bus.dt), 32'd1);
    endtask

    task automatic send_bits(input exp_t e, input int gap);
        for (int b = 0; b < WIDTH; b++) begin
            check_val($sformatf("bit_idx%0d", b), 32'(bus.bit_idx), 32'(b));
            check_val($sformatf("tx_bit%0d", b), 32'(bus.tx_bit), 32'(e.word[b]));
            bus.ack = 1'b1;
            tick();
            bus.ack = 1'b0;
            tick();
            repeat (gap) tick();
        end
        check_val("dt_after_last", 32'(bus.dt), 32'd0);
        check_val("busy_wait_sen", 32'(bus.busy), 32'd1);
        check_val("no_err_send", 32'(bus.err), 32'd0);
    endtask

    task automatic finish_xfer();
        bus.senack = 1'b1;
        tick();
        check_val("cclear", 32'(bus.cclear), 32'd1);
        check_val("done", 32'(bus.done), 32'd1);
        check_val("err_normal", 32'(bus.err), 32'd0);
        bus.senack = 1'b0;
        tick();
        check_val("idle_outs", {bus.busy, bus.grant, bus.ch_id, bus.dt, bus.cclear, bus.done}, '0);
    endtask

    task automatic full_xfer(input logic [NCH-1:0] r, input logic [WIDTH-1:0] w0,
                             input logic [WIDTH-1:0] w1, input bit drop_req);
        exp_t e;
        drive_req(r, w0, w1);
        tick();
        check_grant(e);
        if (drop_req) bus.req = '0;
        send_bits(e, 0);
        finish_xfer();
    endtask

    // Hard stop in case the DUT wedges somewhere the scenario loops do not bound.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   n;
        bus.req     = '0;
        bus.data_in = '0;
        bus.ack     = 1'b0;
        bus.senack  = 1'b0;

        // T1: reset held for 3 cycles with activity on the inputs
        bus.req     = '1;
        bus.data_in = 16'hFFFF;
        repeat (3) begin
            bus.ack = ~bus.ack;
            tick();
            check_val("rst_outs", {bus.busy, bus.grant, bus.ch_id, bus.bit_idx, bus.tx_bit,
                                   bus.dt, bus.cclear, bus.done, bus.err}, '0);
        end
        bus.req = '0;
        bus.ack = 1'b0;
        reset   = 1'b0;
        tick();

        // T2: single transfer on channel 0, word A5
        full_xfer(2'b01, 8'hA5, 8'h3C, 1'b1);
        // channel 1 alone, brings the pointer back to 0
        full_xfer(2'b10, 8'h11, 8'h6B, 1'b1);

        // T3: both channels requesting across two transfers
        full_xfer(2'b11, 8'h5A, 8'hC3, 1'b0);
        full_xfer(2'b11, 8'h5A, 8'hC3, 1'b1);

        // T4: ack high on entry, senack ignored in SEND, senack pre-high for WAIT_SEN
        bus.ack = 1'b1;
        drive_req(2'b01, 8'h96, 8'h00);
        tick();
        check_grant(e);
        bus.req = '0;
        tick();
        tick();
        check_val("ack_held_idx", 32'(bus.bit_idx), 32'd0);
        bus.ack = 1'b0;
        tick();
        check_val("ack_fall_idx", 32'(bus.bit_idx), 32'd0);
        bus.senack = 1'b1;
        tick();
        bus.senack = 1'b0;
        tick();
        check_val("senack_ign_dt", 32'(bus.dt), 32'd1);
        check_val("senack_ign_cclear", 32'(bus.cclear), 32'd0);
        for (int b = 0; b < WIDTH; b++) begin
            check_val($sformatf("t4_tx_bit%0d", b), 32'(bus.tx_bit), 32'(e.word[b]));
            if (b == WIDTH - 1) bus.senack = 1'b1;
            bus.ack = 1'b1;
            tick();
            bus.ack = 1'b0;
            tick();
        end
        check_val("pre_senack_cclear", 32'(bus.cclear), 32'd1);
        check_val("pre_senack_done", 32'(bus.done), 32'd1);
        bus.senack = 1'b0;
        tick();
        check_val("t4_idle", 32'(bus.busy), 32'd0);

        // T5: reset after 3 acks, then channel 0 must win again
        drive_req(2'b01, 8'hF0, 8'h00);
        tick();
        check_grant(e);
        bus.req = '0;
        repeat (3) begin
            bus.ack = 1'b1;
            tick();
            bus.ack = 1'b0;
            tick();
        end
        check_val("pre_rst_idx", 32'(bus.bit_idx), 32'd3);
        reset = 1'b1;
        tick();
        check_val("midrst_outs", {bus.busy, bus.grant, bus.ch_id, bus.bit_idx, bus.tx_bit,
                                  bus.dt, bus.cclear, bus.done, bus.err}, '0);
        reset = 1'b0;
        m_ptr = 0;
        sb_q.delete();
        tick();
        check_val("post_rst_done", 32'(bus.done), 32'd0);
        full_xfer(2'b11, 8'h0F, 8'hFF, 1'b1);

`ifdef X_SEQ_TIMEOUT_EN
        // T6a: no ack at all, expect an abort
        drive_req(2'b01, 8'h81, 8'h00);
        tick();
        check_grant(e);
        bus.req = '0;
        n = 0;
        while (!bus.cclear && n < 30) begin
            tick();
            n++;
        end
        check_val("to_latency", 32'((n >= 10) && (n <= 12)), 32'd1);
        check_val("to_cclear", 32'(bus.cclear), 32'd1);
        check_val("to_err", 32'(bus.err), 32'd1);
        check_val("to_done", 32'(bus.done), 32'd0);
        tick();
        check_val("to_idle", {bus.busy, bus.grant, bus.err}, '0);

        // T6b: acks every 5 cycles keep the transfer alive; pointer moved past ch0
        drive_req(2'b11, 8'h81, 8'h7E);
        tick();
        check_grant(e);
        bus.req = '0;
        send_bits(e, 3);
        finish_xfer();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
